// File: rtl/router_pkg.sv
// Shared router types: flit layout and flit type encoding used by the network interface.
package router_pkg;

    localparam int NUM_OF_FLITS = 8;
    localparam int PAYLOAD_W    = 16;

    typedef enum logic [1:0] {
        HEAD = 2'd0,
        BODY = 2'd1,
        TAIL = 2'd2
    } FLIT_TYPE_t;

    // valid is the MSB, so bit FLIT_SIZE-1 marks a live flit
    typedef struct packed {
        logic                 valid;
        FLIT_TYPE_t           ftype;
        logic [PAYLOAD_W-1:0] payload;
    } FLIT_t;

    localparam int FLIT_SIZE = $bits(FLIT_t);

endpackage

// File: rtl/sfifo.sv
// Synchronous FIFO with combinational head read; simultaneous write and read are both honoured.
module sfifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ni_inject.sv
// Network-interface injection port: grants the generator, frames and buffers one packet,
// and forwards flits to the router under credit-based flow control.
module ni_inject
    import router_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int CREDITS     = 4,
    parameter int MAX_PKT_LEN = NUM_OF_FLITS,
    parameter int TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_transmit,
    output logic        o_send,
    input  FLIT_t       i_flit,
    output FLIT_t       o_flit,
    output logic        o_valid,
    input  logic        i_credit,
    output logic [15:0] o_pkt_count,
    output logic        o_err,
    output logic        o_busy
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(CREDITS) + 1;
    localparam int FCW = $clog2(MAX_PKT_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RECV  = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [FCW-1:0]       flit_cnt;
    logic [FCW-1:0]       flit_cnt_nxt;
    logic [TW-1:0]        tmo_cnt;
    logic [TW-1:0]        tmo_cnt_nxt;
    logic                 wr_req;
    logic                 pkt_done;
    logic                 frame_err;
    logic                 ovf_err;

    logic [FLIT_SIZE-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic [CW-1:0]        credit_cnt;

    FLIT_t                flit_p1;
    logic                 vld_p1;
    logic [15:0]          pkt_count;
    logic                 err;

    logic                 is_head;
    logic                 is_tail;

    assign is_head = (i_flit.ftype == HEAD);
    assign is_tail = (i_flit.ftype == TAIL);

    sfifo #(
        .WIDTH  (FLIT_SIZE),
        .ADDR_W (AW)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_req),
        .wr_data (i_flit),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            flit_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            state    <= next_state;
            flit_cnt <= flit_cnt_nxt;
            tmo_cnt  <= tmo_cnt_nxt;
        end
    end

    // flit_cnt == 0 in RECV means no HEAD has been accepted yet for this grant
    always_comb begin
        next_state   = state;
        flit_cnt_nxt = flit_cnt;
        tmo_cnt_nxt  = tmo_cnt;
        wr_req       = 1'b0;
        pkt_done     = 1'b0;
        frame_err    = 1'b0;
        case (state)
            IDLE: begin
                if (i_transmit && fifo_empty) next_state = GRANT;
            end
            GRANT: begin
                next_state   = RECV;
                tmo_cnt_nxt  = '0;
                flit_cnt_nxt = '0;
            end
            RECV: begin
                if (i_flit.valid) begin
                    tmo_cnt_nxt = '0;
                    if (flit_cnt == '0) begin
                        if (is_head) begin
                            wr_req       = 1'b1;
                            flit_cnt_nxt = FCW'(1);
                        end else begin
                            frame_err = 1'b1;
                        end
                    end else if (is_head) begin
                        frame_err    = 1'b1;
                        wr_req       = 1'b1;
                        flit_cnt_nxt = FCW'(1);
                    end else if (flit_cnt == FCW'(MAX_PKT_LEN)) begin
                        frame_err  = 1'b1;
                        next_state = IDLE;
                    end else begin
                        wr_req       = 1'b1;
                        flit_cnt_nxt = flit_cnt + 1'b1;
                        if (is_tail) begin
                            pkt_done   = 1'b1;
                            next_state = IDLE;
                        end
                    end
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    frame_err  = 1'b1;
                    next_state = IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        o_send = (state == GRANT);
        o_busy = (state != IDLE) || !fifo_empty;
    end

    assign ovf_err = wr_req && fifo_full && !pop;
    assign pop     = !fifo_empty && (credit_cnt != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count <= '0;
            err       <= 1'b0;
        end else begin
            if (pkt_done)             pkt_count <= pkt_count + 1'b1;
            if (frame_err || ovf_err) err       <= 1'b1;
        end
    end

    // A pop and a returned credit in the same cycle cancel out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credit_cnt <= CW'(CREDITS);
        end else if (pop && !i_credit) begin
            credit_cnt <= credit_cnt - 1'b1;
        end else if (!pop && i_credit && (credit_cnt != CW'(CREDITS))) begin
            credit_cnt <= credit_cnt + 1'b1;
        end
    end

    // Stage p1: registered output toward the router
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flit_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            flit_p1 <= pop ? FLIT_t'(fifo_rdata) : '0;
            vld_p1  <= pop;
        end
    end

    assign o_flit      = flit_p1;
    assign o_valid     = vld_p1;
    assign o_pkt_count = pkt_count;
    assign o_err       = err;

endmodule

// File: tb/tb_ni_inject.sv
// Scenario bench for ni_inject: a router-side monitor records forwarded flits and credit use.
module tb_ni_inject;
    import router_pkg::*;

    localparam int CREDITS = 4;
    localparam int MAXL    = 8;
    localparam int TMO     = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_transmit = 1'b0;
    logic        i_credit = 1'b0;
    FLIT_t       i_flit = '0;
    logic        o_send, o_valid, o_err, o_busy;
    FLIT_t       o_flit;
    logic [15:0] o_pkt_count;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cmode = 0;
    int    pulses = 0;
    int    outstanding = 0;
    int    max_out = 0;
    FLIT_t obs_q[$];
    time   obs_t[$];

    ni_inject #(.DEPTH(8), .CREDITS(CREDITS), .MAX_PKT_LEN(MAXL), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .i_transmit(i_transmit), .o_send(o_send),
        .i_flit(i_flit), .o_flit(o_flit), .o_valid(o_valid), .i_credit(i_credit),
        .o_pkt_count(o_pkt_count), .o_err(o_err), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Router model: every received flit occupies one slot until a credit is handed back
    always @(negedge clk) begin
        if (!reset_n) begin
            outstanding = 0;
            max_out = 0;
        end else begin
            if (o_valid) begin
                obs_q.push_back(o_flit);
                obs_t.push_back($time);
                outstanding++;
                if (outstanding > max_out) max_out = outstanding;
            end
            if (cmode == 2) outstanding = 0;
            else if (i_credit && outstanding > 0) outstanding--;
        end
    end

    function automatic FLIT_t mk(FLIT_TYPE_t t, logic [15:0] p);
        FLIT_t f;
        f.valid = 1'b1; f.ftype = t; f.payload = p;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
        case (cmode)
            1: i_credit = (outstanding > 0) && ($urandom_range(0, 2) == 0);
            2: i_credit = 1'b1;
            3: begin
                if (pulses > 0) begin i_credit = 1'b1; pulses--; end
                else i_credit = 1'b0;
            end
            default: i_credit = 1'b0;
        endcase
    endtask

    task automatic do_reset();
        reset_n = 1'b0; i_transmit = 1'b0; i_flit = '0; cmode = 0; pulses = 0;
        tick(); tick();
        reset_n = 1'b1;
        obs_q.delete(); obs_t.delete();
    endtask

    task automatic get_grant(output bit ok);
        ok = 1'b0;
        i_transmit = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            tick();
            if (o_send) ok = 1'b1;
        end
        i_transmit = 1'b0;
        tick();
    endtask

    task automatic send(FLIT_t f);
        i_flit = f; tick(); i_flit = '0;
    endtask

    task automatic wait_idle(int budget);
        for (int k = 0; k < budget && o_busy; k++) tick();
        tick(); tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; #1;
        n_cmp += 6;
        if (o_send !== 1'b0)       begin n_bad++; $display("FAIL rst_send got=%b want=0", o_send); end
        if (o_valid !== 1'b0)      begin n_bad++; $display("FAIL rst_valid got=%b want=0", o_valid); end
        if (o_flit !== '0)         begin n_bad++; $display("FAIL rst_flit got=%h want=0", o_flit); end
        if (o_pkt_count !== 16'd0) begin n_bad++; $display("FAIL rst_pkt got=%0d want=0", o_pkt_count); end
        if (o_err !== 1'b0)        begin n_bad++; $display("FAIL rst_err got=%b want=0", o_err); end
        if (o_busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy got=%b want=0", o_busy); end
    endtask

    task automatic test_basic();
        FLIT_t exp[$];
        FLIT_t got;
        do_reset();
        i_transmit = 1'b1; tick();
        n_cmp++; if (o_send !== 1'b1) begin n_bad++; $display("FAIL basic_send got=%b want=1", o_send); end
        i_transmit = 1'b0; tick();
        n_cmp++; if (o_send !== 1'b0) begin n_bad++; $display("FAIL basic_send_pulse got=%b want=0", o_send); end
        exp.push_back(mk(HEAD, 16'($urandom)));
        exp.push_back(mk(BODY, 16'($urandom)));
        exp.push_back(mk(BODY, 16'($urandom)));
        exp.push_back(mk(TAIL, 16'($urandom)));
        foreach (exp[k]) send(exp[k]);
        repeat (8) tick();
        n_cmp++; if (obs_q.size() != 4) begin n_bad++; $display("FAIL basic_count got=%0d want=4", obs_q.size()); end
        for (int k = 1; k < obs_t.size(); k++) begin
            n_cmp++;
            if (obs_t[k] - obs_t[0] != 10 * k) begin
                n_bad++; $display("FAIL basic_consec flit%0d got=%0t want=%0t", k, obs_t[k] - obs_t[0], 10 * k);
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL basic_flit%0d got=none want=%h", k, exp[k]); end
            else begin
                got = obs_q.pop_front();
                if (got !== exp[k]) begin n_bad++; $display("FAIL basic_flit%0d got=%h want=%h", k, got, exp[k]); end
            end
        end
        n_cmp += 3;
        if (o_pkt_count !== 16'd1) begin n_bad++; $display("FAIL basic_pkt got=%0d want=1", o_pkt_count); end
        if (o_err !== 1'b0)        begin n_bad++; $display("FAIL basic_err got=%b want=0", o_err); end
        if (o_busy !== 1'b0)       begin n_bad++; $display("FAIL basic_busy got=%b want=0", o_busy); end
    endtask

    task automatic test_credit_limit();
        FLIT_t exp[$];
        FLIT_t got;
        bit ok;
        do_reset();
        get_grant(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL cred_grant got=0 want=1"); end
        exp.push_back(mk(HEAD, 16'($urandom)));
        for (int k = 0; k < 4; k++) exp.push_back(mk(BODY, 16'($urandom)));
        exp.push_back(mk(TAIL, 16'($urandom)));
        foreach (exp[k]) send(exp[k]);
        repeat (12) tick();
        n_cmp++; if (obs_q.size() != 4) begin n_bad++; $display("FAIL cred_first_count got=%0d want=4", obs_q.size()); end
        cmode = 3;
        pulses = 1; repeat (4) tick();
        pulses = 1; repeat (8) tick();
        cmode = 0;
        n_cmp++; if (obs_q.size() != 6) begin n_bad++; $display("FAIL cred_total_count got=%0d want=6", obs_q.size()); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL cred_flit%0d got=none want=%h", k, exp[k]); end
            else begin
                got = obs_q.pop_front();
                if (got !== exp[k]) begin n_bad++; $display("FAIL cred_flit%0d got=%h want=%h", k, got, exp[k]); end
            end
        end
        // Credits should now be exhausted: a fresh packet must stay in the buffer
        get_grant(ok);
        send(mk(HEAD, 16'h1111));
        send(mk(TAIL, 16'h2222));
        repeat (10) tick();
        n_cmp += 3;
        if (!ok)              begin n_bad++; $display("FAIL cred_grant2 got=0 want=1"); end
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL cred_zero_out got=%0d want=0", obs_q.size()); end
        if (o_pkt_count !== 16'd2) begin n_bad++; $display("FAIL cred_pkt got=%0d want=2", o_pkt_count); end
    endtask

    task automatic test_credit_sat();
        FLIT_t exp[$];
        FLIT_t got;
        bit ok;
        int len;
        do_reset();
        cmode = 2;
        for (int p = 0; p < 3; p++) begin
            get_grant(ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL sat_grant%0d got=0 want=1", p); end
            len = $urandom_range(2, MAXL);
            for (int k = 0; k < len; k++) begin
                exp.push_back(mk(k == 0 ? HEAD : (k == len - 1 ? TAIL : BODY), 16'($urandom)));
                send(exp[exp.size() - 1]);
            end
        end
        wait_idle(100);
        n_cmp++; if (obs_q.size() != exp.size()) begin n_bad++; $display("FAIL sat_count got=%0d want=%0d", obs_q.size(), exp.size()); end
        foreach (exp[k]) begin
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL sat_flit%0d got=none want=%h", k, exp[k]); end
            else begin
                got = obs_q.pop_front();
                if (got !== exp[k]) begin n_bad++; $display("FAIL sat_flit%0d got=%h want=%h", k, got, exp[k]); end
            end
        end
        cmode = 0;
        repeat (3) tick();
        get_grant(ok);
        send(mk(HEAD, 16'($urandom)));
        for (int k = 0; k < 4; k++) send(mk(BODY, 16'($urandom)));
        send(mk(TAIL, 16'($urandom)));
        repeat (12) tick();
        n_cmp += 2;
        if (!ok) begin n_bad++; $display("FAIL sat_grant_last got=0 want=1"); end
        if (obs_q.size() != CREDITS) begin n_bad++; $display("FAIL sat_bound got=%0d want=%0d", obs_q.size(), CREDITS); end
    endtask

    task automatic test_body_first();
        FLIT_t exp[$];
        FLIT_t got;
        bit ok;
        do_reset();
        cmode = 1;
        get_grant(ok);
        send(mk(BODY, 16'hBAD0));
        repeat (3) tick();
        n_cmp += 4;
        if (!ok)               begin n_bad++; $display("FAIL bodyfirst_grant got=0 want=1"); end
        if (o_err !== 1'b1)    begin n_bad++; $display("FAIL bodyfirst_err got=%b want=1", o_err); end
        if (o_busy !== 1'b1)   begin n_bad++; $display("FAIL bodyfirst_recv got=%b want=1", o_busy); end
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL bodyfirst_dropped got=%0d want=0", obs_q.size()); end
        exp.push_back(mk(HEAD, 16'($urandom)));
        exp.push_back(mk(BODY, 16'($urandom)));
        exp.push_back(mk(TAIL, 16'($urandom)));
        foreach (exp[k]) send(exp[k]);
        wait_idle(60);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL bodyfirst_flit%0d got=none want=%h", k, exp[k]); end
            else begin
                got = obs_q.pop_front();
                if (got !== exp[k]) begin n_bad++; $display("FAIL bodyfirst_flit%0d got=%h want=%h", k, got, exp[k]); end
            end
        end
        n_cmp += 2;
        if (o_pkt_count !== 16'd1) begin n_bad++; $display("FAIL bodyfirst_pkt got=%0d want=1", o_pkt_count); end
        if (o_err !== 1'b1)        begin n_bad++; $display("FAIL bodyfirst_sticky got=%b want=1", o_err); end
    endtask

    task automatic test_timeout();
        FLIT_t h;
        FLIT_t got;
        bit ok;
        do_reset();
        cmode = 1;
        get_grant(ok);
        h = mk(HEAD, 16'($urandom));
        send(h);
        repeat (TMO - 1) tick();
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL tmo_early got=%b want=0", o_err); end
        repeat (2) tick();
        wait_idle(40);
        n_cmp += 5;
        if (!ok)                   begin n_bad++; $display("FAIL tmo_grant got=0 want=1"); end
        if (o_err !== 1'b1)        begin n_bad++; $display("FAIL tmo_err got=%b want=1", o_err); end
        if (o_busy !== 1'b0)       begin n_bad++; $display("FAIL tmo_idle got=%b want=0", o_busy); end
        if (o_pkt_count !== 16'd0) begin n_bad++; $display("FAIL tmo_pkt got=%0d want=0", o_pkt_count); end
        if (obs_q.size() != 1)     begin n_bad++; $display("FAIL tmo_count got=%0d want=1", obs_q.size()); end
        else begin
            got = obs_q.pop_front();
            n_cmp++;
            if (got !== h) begin n_bad++; $display("FAIL tmo_head got=%h want=%h", got, h); end
        end
    endtask

    task automatic test_overlength();
        FLIT_t exp[$];
        FLIT_t got;
        bit ok;
        do_reset();
        cmode = 1;
        get_grant(ok);
        exp.push_back(mk(HEAD, 16'($urandom)));
        for (int k = 1; k < MAXL; k++) exp.push_back(mk(BODY, 16'($urandom)));
        foreach (exp[k]) send(exp[k]);
        send(mk(BODY, 16'hDEAD));
        send(mk(TAIL, 16'hBEEF));
        wait_idle(100);
        n_cmp += 4;
        if (!ok)                   begin n_bad++; $display("FAIL ovl_grant got=0 want=1"); end
        if (o_err !== 1'b1)        begin n_bad++; $display("FAIL ovl_err got=%b want=1", o_err); end
        if (o_busy !== 1'b0)       begin n_bad++; $display("FAIL ovl_idle got=%b want=0", o_busy); end
        if (o_pkt_count !== 16'd0) begin n_bad++; $display("FAIL ovl_pkt got=%0d want=0", o_pkt_count); end
        n_cmp++; if (obs_q.size() != MAXL) begin n_bad++; $display("FAIL ovl_count got=%0d want=%0d", obs_q.size(), MAXL); end
        for (int k = 0; k < MAXL && obs_q.size() > 0; k++) begin
            got = obs_q.pop_front();
            n_cmp++;
            if (got !== exp[k]) begin n_bad++; $display("FAIL ovl_flit%0d got=%h want=%h", k, got, exp[k]); end
        end
    endtask

    task automatic test_random();
        FLIT_t exp[$];
        FLIT_t got;
        bit ok;
        int len;
        do_reset();
        cmode = 1;
        for (int p = 0; p < 6; p++) begin
            get_grant(ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd_grant%0d got=0 want=1", p); end
            len = $urandom_range(2, MAXL);
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 5)) tick();
                exp.push_back(mk(k == 0 ? HEAD : (k == len - 1 ? TAIL : BODY), 16'($urandom)));
                send(exp[exp.size() - 1]);
            end
        end
        wait_idle(300);
        n_cmp++; if (obs_q.size() != exp.size()) begin n_bad++; $display("FAIL rnd_count got=%0d want=%0d", obs_q.size(), exp.size()); end
        foreach (exp[k]) begin
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL rnd_flit%0d got=none want=%h", k, exp[k]); end
            else begin
                got = obs_q.pop_front();
                if (got !== exp[k]) begin n_bad++; $display("FAIL rnd_flit%0d got=%h want=%h", k, got, exp[k]); end
            end
        end
        n_cmp += 3;
        if (o_pkt_count !== 16'd6) begin n_bad++; $display("FAIL rnd_pkt got=%0d want=6", o_pkt_count); end
        if (o_err !== 1'b0)        begin n_bad++; $display("FAIL rnd_err got=%b want=0", o_err); end
        if (max_out > CREDITS)     begin n_bad++; $display("FAIL rnd_credit_bound got=%0d want<=%0d", max_out, CREDITS); end
    endtask

    task automatic test_reset_mid();
        FLIT_t exp[$];
        FLIT_t got;
        bit ok;
        do_reset();
        cmode = 0;
        get_grant(ok);
        send(mk(HEAD, 16'($urandom)));
        send(mk(BODY, 16'($urandom)));
        reset_n = 1'b0; #1;
        n_cmp += 7;
        if (!ok)                   begin n_bad++; $display("FAIL mid_grant got=0 want=1"); end
        if (o_send !== 1'b0)       begin n_bad++; $display("FAIL mid_send got=%b want=0", o_send); end
        if (o_valid !== 1'b0)      begin n_bad++; $display("FAIL mid_valid got=%b want=0", o_valid); end
        if (o_flit !== '0)         begin n_bad++; $display("FAIL mid_flit got=%h want=0", o_flit); end
        if (o_pkt_count !== 16'd0) begin n_bad++; $display("FAIL mid_pkt got=%0d want=0", o_pkt_count); end
        if (o_err !== 1'b0)        begin n_bad++; $display("FAIL mid_err got=%b want=0", o_err); end
        if (o_busy !== 1'b0)       begin n_bad++; $display("FAIL mid_busy got=%b want=0", o_busy); end
        do_reset();
        cmode = 1;
        get_grant(ok);
        exp.push_back(mk(HEAD, 16'($urandom)));
        exp.push_back(mk(BODY, 16'($urandom)));
        exp.push_back(mk(TAIL, 16'($urandom)));
        foreach (exp[k]) send(exp[k]);
        wait_idle(60);
        n_cmp += 3;
        if (!ok)                   begin n_bad++; $display("FAIL mid_regrant got=0 want=1"); end
        if (o_pkt_count !== 16'd1) begin n_bad++; $display("FAIL mid_pkt_after got=%0d want=1", o_pkt_count); end
        if (obs_q.size() != 3)     begin n_bad++; $display("FAIL mid_count got=%0d want=3", obs_q.size()); end
        for (int k = 0; k < 3 && obs_q.size() > 0; k++) begin
            got = obs_q.pop_front();
            n_cmp++;
            if (got !== exp[k]) begin n_bad++; $display("FAIL mid_flit%0d got=%h want=%h", k, got, exp[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_credit_limit();
        test_credit_sat();
        test_body_first();
        test_timeout();
        test_overlength();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
